// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
//   mode_e          : output mode of a divider channel (toggle / pulse)
//   DEF_DIV_DEFAULT : default terminal count loaded into every channel on reset
package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int unsigned DEF_DIV_DEFAULT = 32'd12499999;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counts 0..div, ticks for one cycle after each terminal
// count and produces either a square wave (toggle) or a copy of tick (pulse).
// Reconfiguration is deferred to the next terminal count so periods are never
// truncated.
//   clk, rst  : clock, synchronous active-high reset
//   en        : channel enable; low clears and holds the channel
//   sync      : restart in phase and apply any pending configuration
//   we        : configuration write aimed at this channel
//   wr_div    : terminal count carried by the write
//   wr_mode   : mode carried by the write (0 toggle, 1 pulse)
//   clk_out   : registered divided output
//   tick      : registered one-cycle terminal-count pulse
//   pend      : a written configuration is waiting to be applied
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    mode_e            mode_q, mode_d;
    mode_e            pmode_q, pmode_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] next_div;
    mode_e            next_mode;

    always_comb begin
        // Configuration that becomes active on an apply event: a write in the
        // same cycle beats an older pending one.
        next_div  = pend_q ? pdiv_q : div_q;
        next_mode = pend_q ? pmode_q : mode_q;
        if (we) begin
            next_div  = wr_div;
            next_mode = mode_e'(wr_mode);
        end

        cnt_d     = cnt_q;
        div_d     = div_q;
        mode_d    = mode_q;
        pdiv_d    = pdiv_q;
        pmode_d   = pmode_q;
        pend_d    = pend_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (sync) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            div_d     = next_div;
            mode_d    = next_mode;
            pend_d    = 1'b0;
        end else if (!en) begin
            // An idle channel has no period to protect, so writes land directly.
            cnt_d     = '0;
            clk_out_d = 1'b0;
            if (we) begin
                div_d  = wr_div;
                mode_d = mode_e'(wr_mode);
                pend_d = 1'b0;
            end
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = next_div;
            mode_d = next_mode;
            pend_d = 1'b0;
            // Leaving toggle mode parks the output low; entering it starts a
            // fresh high half-period.
            if (next_mode == MODE_PULSE) begin
                clk_out_d = (mode_q == MODE_PULSE);
            end else if (mode_q == MODE_PULSE) begin
                clk_out_d = 1'b1;
            end else begin
                clk_out_d = ~clk_out_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mode_q == MODE_PULSE) begin
                clk_out_d = 1'b0;
            end
            if (we) begin
                pdiv_d  = wr_div;
                pmode_d = mode_e'(wr_mode);
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= RST_DIV;
            mode_q    <= MODE_TOGGLE;
            pdiv_q    <= RST_DIV;
            pmode_q   <= MODE_TOGGLE;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            pdiv_q    <= pdiv_d;
            pmode_q   <= pmode_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH independent programmable clock dividers sharing one
// configuration port and one phase-sync input.
//   clk, rst  : clock, synchronous active-high reset
//   ch_en     : per-channel enable
//   sync      : restart all channels in phase
//   cfg_we    : one-cycle configuration write strobe
//   cfg_ch    : target channel (indices >= N_CH are ignored)
//   cfg_div   : new terminal count
//   cfg_mode  : new mode (0 toggle, 1 pulse)
//   clk_out   : divided output per channel
//   tick      : terminal-count pulse per channel
//   cfg_pend  : per-channel pending-configuration flag
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_CH-1:0]                             ch_en,
    input  logic                                        sync,
    input  logic                                        cfg_we,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_div,
    input  logic                                        cfg_mode,
    output logic [N_CH-1:0]                             clk_out,
    output logic [N_CH-1:0]                             tick,
    output logic [N_CH-1:0]                             cfg_pend
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Equality decode only matches existing channels, so out-of-range
    // indices fall through without touching any state.
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .sync    (sync),
            .we      (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (cfg_pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. A third channel is instantiated so
// the 2-bit cfg_ch can express an out-of-range index (3).
module tb_clk_div_bank;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 3;

    logic             clk;
    logic             rst;
    logic [N_CH-1:0]  ch_en;
    logic             sync;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic [N_CH-1:0]  clk_out;
    logic [N_CH-1:0]  tick;
    logic [N_CH-1:0]  cfg_pend;

    int testCount = 0;
    int failCount = 0;

    clk_div_bank #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_pend (cfg_pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each channel tracks its position within the current
    // period, the number of completed periods since it was last cleared
    // (toggle output is the parity of that count), and its pending config.
    int unsigned mDiv[N_CH];
    int unsigned mPos[N_CH];
    int unsigned mWraps[N_CH];
    int unsigned mPendDiv[N_CH];
    bit          mPulse[N_CH];
    bit          mPendPulse[N_CH];
    bit          mPend[N_CH];
    bit          mTick[N_CH];
    bit          mClk[N_CH];

    task automatic modelStep(input bit r, input logic [N_CH-1:0] en, input bit sy,
                             input bit w, input int ch, input int dv, input bit md);
        for (int c = 0; c < N_CH; c++) begin
            bit hit;
            bit wasPulse;
            hit      = w && (ch == c);
            wasPulse = mPulse[c];
            if (r) begin
                mDiv[c]   = DEF_DIV;
                mPulse[c] = 1'b0;
                mPos[c]   = 0;
                mPend[c]  = 1'b0;
                mTick[c]  = 1'b0;
                mWraps[c] = 0;
            end else if (sy || !en[c]) begin
                if (hit) begin
                    mDiv[c]   = dv;
                    mPulse[c] = md;
                    mPend[c]  = 1'b0;
                end else if (sy && mPend[c]) begin
                    mDiv[c]   = mPendDiv[c];
                    mPulse[c] = mPendPulse[c];
                    mPend[c]  = 1'b0;
                end
                mPos[c]   = 0;
                mTick[c]  = 1'b0;
                mWraps[c] = 0;
            end else if (mPos[c] == mDiv[c]) begin
                if (hit) begin
                    mDiv[c]   = dv;
                    mPulse[c] = md;
                end else if (mPend[c]) begin
                    mDiv[c]   = mPendDiv[c];
                    mPulse[c] = mPendPulse[c];
                end
                mPend[c] = 1'b0;
                mPos[c]  = 0;
                mTick[c] = 1'b1;
                if (!mPulse[c]) mWraps[c] = wasPulse ? 1 : mWraps[c] + 1;
            end else begin
                mPos[c]  = mPos[c] + 1;
                mTick[c] = 1'b0;
                if (hit) begin
                    mPendDiv[c]   = dv;
                    mPendPulse[c] = md;
                    mPend[c]      = 1'b1;
                end
            end
            if (mPulse[c]) mClk[c] = mTick[c] && wasPulse && !r;
            else           mClk[c] = (mWraps[c] % 2) == 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance DUT and model, compare outputs.
    task automatic applyStimulus(input bit r, input logic [N_CH-1:0] en, input bit sy,
                                 input bit w, input int ch, input int dv, input bit md);
        logic [N_CH-1:0] eTick, eClk, ePend;
        rst      = r;
        ch_en    = en;
        sync     = sy;
        cfg_we   = w;
        cfg_ch   = 2'(ch);
        cfg_div  = CNT_W'(dv);
        cfg_mode = md;
        @(posedge clk);
        modelStep(r, en, sy, w, ch, dv, md);
        #1;
        for (int c = 0; c < N_CH; c++) begin
            eTick[c] = mTick[c];
            eClk[c]  = mClk[c];
            ePend[c] = mPend[c];
        end
        checkOutput("tick", 32'(tick), 32'(eTick));
        checkOutput("clk_out", 32'(clk_out), 32'(eClk));
        checkOutput("cfg_pend", 32'(cfg_pend), 32'(ePend));
    endtask

    task automatic idle(input logic [N_CH-1:0] en, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, en, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        int tickCount;
        int clkHigh;
        logic [N_CH-1:0] rEn;

        applyStimulus(1'b1, '0, 1'b0, 1'b0, 0, 0, 1'b0);
        applyStimulus(1'b1, '0, 1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("rst_outputs", 32'({tick, clk_out, cfg_pend}), 32'd0);

        // Default divisor 3: four ticks and a half-high square wave in 16 cycles.
        tickCount = 0;
        clkHigh   = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b0, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0);
            tickCount += int'(tick[0]);
            clkHigh   += int'(clk_out[1]);
            if (k == 3) checkOutput("first_tick", 32'(tick), 32'b011);
        end
        checkOutput("tick_count_div3", 32'(tickCount), 32'd4);
        checkOutput("duty_div3", 32'(clkHigh), 32'd8);

        // Mid-period write on ch1 stays pending until its next terminal count.
        idle(3'b011, 1);
        applyStimulus(1'b0, 3'b011, 1'b0, 1'b1, 1, 1, 1'b0);
        checkOutput("pend_set", 32'(cfg_pend), 32'b010);
        idle(3'b011, 12);

        // Direct write to a disabled channel, then enable: pulse every cycle.
        idle(3'b010, 2);
        applyStimulus(1'b0, 3'b010, 1'b0, 1'b1, 0, 0, 1'b1);
        checkOutput("no_pend_disabled", 32'(cfg_pend[0]), 32'd0);
        idle(3'b011, 2);
        for (int k = 0; k < 4; k++) begin
            idle(3'b011, 1);
            checkOutput("div0_pulse", 32'({clk_out[0], tick[0]}), 32'b11);
        end

        // Write ch1 exactly on its terminal-count cycle: active immediately.
        for (int k = 0; k < 20 && mPos[1] != mDiv[1]; k++) idle(3'b011, 1);
        applyStimulus(1'b0, 3'b011, 1'b0, 1'b1, 1, 5, 1'b0);
        checkOutput("tc_write_no_pend", 32'(cfg_pend[1]), 32'd0);
        idle(3'b011, 5);
        checkOutput("tc_write_gap", 32'(tick[1]), 32'd0);
        idle(3'b011, 1);
        checkOutput("tc_write_next_tick", 32'(tick[1]), 32'd1);

        // Pending write on ch0, then sync realigns everything.
        idle(3'b011, 2);
        applyStimulus(1'b0, 3'b011, 1'b0, 1'b1, 0, 2, 1'b0);
        idle(3'b011, 1);
        applyStimulus(1'b0, 3'b011, 1'b1, 1'b0, 0, 0, 1'b0);
        checkOutput("sync_clear", 32'({tick, clk_out, cfg_pend}), 32'd0);
        idle(3'b011, 18);

        // Reset with a write pending, then an out-of-range write.
        applyStimulus(1'b0, 3'b011, 1'b0, 1'b1, 1, 2, 1'b1);
        applyStimulus(1'b1, 3'b011, 1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("rst_mid", 32'({tick, clk_out, cfg_pend}), 32'd0);
        applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 3, 0, 1'b1);
        idle(3'b111, 10);

        // Randomized traffic against the model.
        rEn = 3'b111;
        for (int k = 0; k < 3000; k++) begin
            bit r, sy, w;
            if ($urandom_range(0, 19) == 0) rEn = 3'($urandom);
            r  = ($urandom_range(0, 499) == 0);
            sy = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 7) == 0);
            applyStimulus(r, rEn, sy, w, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 6)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 2: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32: counter and divisor width in bits.
REQ-003 Parameter DEF_DIV, default 12499999: reset terminal count for every channel.
REQ-004 clk  input  1  clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 ch_en  input  N_CH  per-channel enable.
REQ-007 sync  input  1  restarts all channels in phase.
REQ-008 cfg_we  input  1  configuration write strobe; valid for one cycle.
REQ-009 cfg_ch  input  max(1,clog2(N_CH))  target channel of the write.
REQ-010 cfg_div  input  CNT_W  new terminal count.
REQ-011 cfg_mode  input  1  new mode: 0 = toggle (square wave), 1 = pulse.
REQ-012 clk_out  output  N_CH  registered divided output per channel.
REQ-013 tick  output  N_CH  registered one-cycle pulse at each terminal count.
REQ-014 cfg_pend  output  N_CH  high while a written configuration is not yet applied.

Function
REQ-015 Each channel SHALL hold an active divisor (div), an active mode, a counter cnt, and a pending divisor/mode with a pending flag.
REQ-016 An enabled channel SHALL increment cnt each cycle; when cnt == div it SHALL load cnt <= 0 and set tick high for exactly the next cycle.
REQ-017 The tick period SHALL be div+1 cycles; div == 0 SHALL give tick high every cycle.
REQ-018 In toggle mode, clk_out SHALL invert on each terminal count: period 2*(div+1) cycles, 50% duty; div == 0 gives clk/2.
REQ-019 In pulse mode, clk_out SHALL equal tick, with the same register timing.
REQ-020 A disabled channel (ch_en low) SHALL clear cnt, clk_out and tick to 0 and hold them there; counting SHALL resume from cnt = 0 on the cycle after re-enable.
REQ-021 cfg_we to an enabled channel SHALL store cfg_div/cfg_mode as pending and set cfg_pend on the next cycle.
REQ-022 Pending configuration SHALL become active at the channel's next terminal count; cnt restarts at 0 with the new div; cfg_pend clears in the same cycle. This prevents truncated or glitched periods.
REQ-023 cfg_we to a disabled channel SHALL write the active div/mode directly, without setting cfg_pend.
REQ-024 If cfg_we hits a channel on the same cycle as its terminal count, the written values SHALL become active immediately and cfg_pend SHALL stay low.
REQ-025 A second cfg_we before the pending configuration applies SHALL overwrite the pending values (last write wins).
REQ-026 cfg_we with cfg_ch >= N_CH SHALL be ignored.
REQ-027 On a mode change from toggle to pulse at apply time, clk_out SHALL go to 0 on the next cycle.
REQ-028 sync high SHALL, on the next edge, clear all cnt, clk_out and tick, and apply all pending configurations. A cfg_we in the same cycle SHALL be applied immediately. sync SHALL take priority over terminal count.
REQ-029 rst SHALL take priority over sync, cfg_we and ch_en.

Reset
REQ-030 On rst, every channel SHALL set cnt = 0, div = DEF_DIV, mode = toggle, clk_out = 0, tick = 0, pending cleared and cfg_pend = 0.
REQ-031 The first terminal count after reset release SHALL occur with tick high DEF_DIV+1 cycles after the first enabled cycle.

Structure
REQ-032 Package clk_div_pkg SHALL hold the mode constants (MODE_TOGGLE = 0, MODE_PULSE = 1) and the DEF_DIV default value.
REQ-033 One sub-module, clk_div_chan, SHALL implement a single channel; clk_div_bank SHALL instantiate it N_CH times and decode cfg_ch.

Verification (N_CH = 2, CNT_W = 8, DEF_DIV = 3)
REQ-034 Reset, then ch_en = 2'b11 -> tick on each channel every 4 cycles; clk_out period 8 cycles, 50% duty.
REQ-035 Write ch1 div = 1 mid-period -> cfg_pend[1] high until ch1's next terminal count; then tick period 2 and clk_out period 4; ch0 unaffected.
REQ-036 Write ch0 div = 0, mode = pulse, with ch0 disabled; then enable -> clk_out[0] = tick[0] = 1 every cycle; cfg_pend[0] never high.
REQ-037 Write ch1 div = 5 on the exact terminal-count cycle -> next tick six cycles later; cfg_pend[1] stays 0.
REQ-038 Channels out of phase, pending write on ch0, assert sync -> both cnt = 0, outputs 0, new div active; thereafter ticks aligned to the new periods.
REQ-039 Assert rst mid-period with a write pending -> all outputs 0, div = 3, cfg_pend = 0; write to cfg_ch = 3 (out of range) -> no state change.
